// File: rtl/hdr_ccc_sequencer.sv
// -----------------------------------------------------------------------------
// hdr_ccc_sequencer
//
// Sequences one HDR Common Command Code frame. The frame starts with a
// broadcast 7E header, an ACK and the CCC word. Broadcast commands then send
// their payload words and a CRC. Direct commands send the header CRC, then
// serve each target in turn: restart, target header, ACK, payload and CRC. A
// NACKed target is retried up to RETRY_MAX times and then skipped. The frame
// ends with an exit pattern (TOC = 1) or a restart pattern (TOC = 0).
//
// Ports
//   i_sys_clk / i_sys_rst     clock, asynchronous active-low reset
//   i_engine_en               start request, honoured only in IDLE
//   i_regf_*                  command fields, latched at start
//   i_tx_mode_done            transmitter finished the current word/pattern
//   i_rx_mode_done            receiver finished the current word
//   i_rx_ack / i_rx_error     ACK bit (ACK mode) / receive CRC or parity error
//   i_sclstall_stall_done     SCL stall for a restart/exit has completed
//   o_tx_en / o_tx_mode       transmitter enable and word type
//   o_rx_en / o_rx_mode       receiver enable and word type
//   o_sclstall_en             SCL stall request during restart/exit
//   o_regf_rd_en / _wr_en     payload fetch / store strobes, o_regf_addr
//   o_tgt_idx                 target currently being served
//   o_engine_done             one-cycle end-of-frame pulse
//   o_error / o_error_code    sticky error flag, 01 = NACK, 10 = receive error
// -----------------------------------------------------------------------------
module hdr_ccc_sequencer #(
    parameter int unsigned MAX_TARGETS = 4,
    parameter int unsigned DATA_LEN_W  = 16,
    parameter int unsigned RETRY_MAX   = 2
) (
    input  logic                             i_sys_clk,
    input  logic                             i_sys_rst,
    input  logic                             i_engine_en,
    input  logic [7:0]                       i_regf_CMD,
    input  logic                             i_regf_DBP,
    input  logic                             i_regf_TOC,
    input  logic                             i_regf_RnW,
    input  logic [DATA_LEN_W-1:0]            i_regf_DATA_LENGTH,
    input  logic [$clog2(MAX_TARGETS+1)-1:0] i_regf_TGT_CNT,
    input  logic                             i_tx_mode_done,
    input  logic                             i_rx_mode_done,
    input  logic                             i_rx_ack,
    input  logic                             i_rx_error,
    input  logic                             i_sclstall_stall_done,
    output logic                             o_tx_en,
    output logic [3:0]                       o_tx_mode,
    output logic                             o_rx_en,
    output logic [2:0]                       o_rx_mode,
    output logic                             o_sclstall_en,
    output logic                             o_regf_rd_en,
    output logic                             o_regf_wr_en,
    output logic [7:0]                       o_regf_addr,
    output logic [$clog2(MAX_TARGETS)-1:0]   o_tgt_idx,
    output logic                             o_engine_done,
    output logic                             o_error,
    output logic [1:0]                       o_error_code
);

    localparam int unsigned TCNT_W = $clog2(MAX_TARGETS + 1);
    localparam int unsigned TIDX_W = $clog2(MAX_TARGETS);
    localparam int unsigned RTRY_W = $clog2(RETRY_MAX + 2);

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StBcHdr   = 4'd1;
    localparam logic [3:0] StAck     = 4'd2;
    localparam logic [3:0] StCccWord = 4'd3;
    localparam logic [3:0] StData    = 4'd4;
    localparam logic [3:0] StCrc     = 4'd5;
    localparam logic [3:0] StRestart = 4'd6;
    localparam logic [3:0] StTgtHdr  = 4'd7;
    localparam logic [3:0] StTgtAck  = 4'd8;
    localparam logic [3:0] StTgtData = 4'd9;
    localparam logic [3:0] StTgtCrc  = 4'd10;
    localparam logic [3:0] StExit    = 4'd11;
    localparam logic [3:0] StDone    = 4'd12;

    localparam logic [3:0] TxHdr7e   = 4'd0;
    localparam logic [3:0] TxCccDb   = 4'd1;
    localparam logic [3:0] TxCccZero = 4'd2;
    localparam logic [3:0] TxData    = 4'd3;
    localparam logic [3:0] TxCrc     = 4'd4;
    localparam logic [3:0] TxTgtHdr  = 4'd5;
    localparam logic [3:0] TxRestart = 4'd6;
    localparam logic [3:0] TxExit    = 4'd7;

    localparam logic [2:0] RxAck     = 3'd0;
    localparam logic [2:0] RxData    = 3'd1;

    localparam logic [1:0] ErrNack   = 2'b01;
    localparam logic [1:0] ErrRx     = 2'b10;

    // Control state
    logic [3:0]            state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic                  dbp_q, dbp_d;
    logic                  toc_q, toc_d;
    logic                  rnw_q, rnw_d;
    logic [DATA_LEN_W-1:0] len_q, len_d;
    logic [TCNT_W-1:0]     tgt_cnt_q, tgt_cnt_d;
    logic [DATA_LEN_W-1:0] word_q, word_d;
    logic                  fetch_q, fetch_d;
    logic [TIDX_W-1:0]     tgt_idx_q, tgt_idx_d;
    logic [RTRY_W-1:0]     retry_q, retry_d;
    logic                  last_q, last_d;
    logic                  stall_seen_q, stall_seen_d;
    logic                  txd_seen_q, txd_seen_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    // Output registers
    logic       tx_en_q, tx_en_d;
    logic [3:0] tx_mode_q, tx_mode_d;
    logic       rx_en_q, rx_en_d;
    logic [2:0] rx_mode_q, rx_mode_d;
    logic       stall_en_q, stall_en_d;
    logic       rd_en_q, rd_en_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] addr_q, addr_d;
    logic       done_q, done_d;

    logic                  direct;
    logic [DATA_LEN_W-1:0] nwords;
    logic                  word_last;
    logic                  more_tgts;
    logic                  pattern_done;
    logic                  unused_cmd_bits;

    // Only the direct/broadcast bit steers sequencing; the code itself is
    // serialised by the transmitter.
    assign unused_cmd_bits = ^cmd_q[6:0];

    assign direct       = cmd_q[7];
    assign nwords       = (len_q >> 1) + DATA_LEN_W'(len_q[0]);
    assign word_last    = (word_q + DATA_LEN_W'(1)) == nwords;
    assign more_tgts    = (TCNT_W'(tgt_idx_q) + TCNT_W'(1)) < tgt_cnt_q;
    // Stall-done and tx-done may land in different cycles; remember each.
    assign pattern_done = (stall_seen_q | i_sclstall_stall_done) &
                          (txd_seen_q | i_tx_mode_done);

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        dbp_d        = dbp_q;
        toc_d        = toc_q;
        rnw_d        = rnw_q;
        len_d        = len_q;
        tgt_cnt_d    = tgt_cnt_q;
        word_d       = word_q;
        fetch_d      = fetch_q;
        tgt_idx_d    = tgt_idx_q;
        retry_d      = retry_q;
        last_d       = last_q;
        stall_seen_d = stall_seen_q;
        txd_seen_d   = txd_seen_q;
        err_d        = err_q;
        err_code_d   = err_code_q;

        case (state_q)
            StIdle: begin
                if (i_engine_en) begin
                    cmd_d        = i_regf_CMD;
                    dbp_d        = i_regf_DBP;
                    toc_d        = i_regf_TOC;
                    rnw_d        = i_regf_RnW;
                    len_d        = i_regf_DATA_LENGTH;
                    tgt_cnt_d    = (i_regf_TGT_CNT > TCNT_W'(MAX_TARGETS)) ?
                                   TCNT_W'(MAX_TARGETS) : i_regf_TGT_CNT;
                    word_d       = '0;
                    fetch_d      = 1'b0;
                    tgt_idx_d    = '0;
                    retry_d      = '0;
                    last_d       = 1'b0;
                    stall_seen_d = 1'b0;
                    txd_seen_d   = 1'b0;
                    err_d        = 1'b0;
                    err_code_d   = 2'b00;
                    state_d      = StBcHdr;
                end
            end
            StBcHdr: begin
                if (i_tx_mode_done) state_d = StAck;
            end
            StAck: begin
                if (i_rx_error) begin
                    err_d      = 1'b1;
                    err_code_d = ErrRx;
                    state_d    = StExit;
                end else if (i_rx_mode_done) begin
                    if (i_rx_ack) begin
                        state_d = StCccWord;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ErrNack;
                        state_d    = StExit;
                    end
                end
            end
            StCccWord: begin
                if (i_tx_mode_done) begin
                    word_d = '0;
                    if (!direct && (nwords != '0)) begin
                        fetch_d = 1'b1;
                        state_d = StData;
                    end else begin
                        state_d = StCrc;
                    end
                end
            end
            StData: begin
                // First cycle of each word is the register-file fetch.
                if (fetch_q) begin
                    fetch_d = 1'b0;
                end else if (i_tx_mode_done) begin
                    word_d = word_q + DATA_LEN_W'(1);
                    if (word_last) state_d = StCrc;
                    else           fetch_d = 1'b1;
                end
            end
            StCrc: begin
                if (i_tx_mode_done) begin
                    if (!direct || (tgt_cnt_q == '0)) begin
                        if (toc_q) begin
                            state_d = StExit;
                        end else begin
                            last_d  = 1'b1;
                            state_d = StRestart;
                        end
                    end else begin
                        tgt_idx_d = '0;
                        retry_d   = '0;
                        last_d    = 1'b0;
                        state_d   = StRestart;
                    end
                end
            end
            StRestart, StExit: begin
                stall_seen_d = stall_seen_q | i_sclstall_stall_done;
                txd_seen_d   = txd_seen_q | i_tx_mode_done;
                if (pattern_done) begin
                    stall_seen_d = 1'b0;
                    txd_seen_d   = 1'b0;
                    if (state_q == StExit || last_q) state_d = StDone;
                    else                             state_d = StTgtHdr;
                end
            end
            StTgtHdr: begin
                if (i_tx_mode_done) state_d = StTgtAck;
            end
            StTgtAck: begin
                if (i_rx_error) begin
                    err_d      = 1'b1;
                    err_code_d = ErrRx;
                    state_d    = StExit;
                end else if (i_rx_mode_done) begin
                    if (i_rx_ack) begin
                        word_d = '0;
                        if (nwords == '0) begin
                            state_d = StTgtCrc;
                        end else begin
                            fetch_d = !rnw_q;
                            state_d = StTgtData;
                        end
                    end else if (retry_q < RTRY_W'(RETRY_MAX)) begin
                        retry_d = retry_q + RTRY_W'(1);
                        last_d  = 1'b0;
                        state_d = StRestart;
                    end else begin
                        // Retries exhausted: flag it and move on.
                        retry_d = '0;
                        err_d   = 1'b1;
                        if (err_code_q != ErrRx) err_code_d = ErrNack;
                        if (more_tgts) begin
                            tgt_idx_d = tgt_idx_q + TIDX_W'(1);
                            last_d    = 1'b0;
                            state_d   = StRestart;
                        end else if (toc_q) begin
                            state_d = StExit;
                        end else begin
                            last_d  = 1'b1;
                            state_d = StRestart;
                        end
                    end
                end
            end
            StTgtData: begin
                if (rnw_q) begin
                    if (i_rx_error) begin
                        err_d      = 1'b1;
                        err_code_d = ErrRx;
                        state_d    = StExit;
                    end else if (i_rx_mode_done) begin
                        word_d = word_q + DATA_LEN_W'(1);
                        if (word_last) state_d = StTgtCrc;
                    end
                end else if (fetch_q) begin
                    fetch_d = 1'b0;
                end else if (i_tx_mode_done) begin
                    word_d = word_q + DATA_LEN_W'(1);
                    if (word_last) state_d = StTgtCrc;
                    else           fetch_d = 1'b1;
                end
            end
            StTgtCrc: begin
                if (i_tx_mode_done) begin
                    retry_d = '0;
                    if (more_tgts) begin
                        tgt_idx_d = tgt_idx_q + TIDX_W'(1);
                        last_d    = 1'b0;
                        state_d   = StRestart;
                    end else if (toc_q) begin
                        state_d = StExit;
                    end else begin
                        last_d  = 1'b1;
                        state_d = StRestart;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        tx_en_d    = 1'b0;
        tx_mode_d  = 4'd0;
        rx_en_d    = 1'b0;
        rx_mode_d  = 3'd0;
        stall_en_d = 1'b0;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;
        wr_en_d    = (state_q == StTgtData) && rnw_q && i_rx_mode_done && !i_rx_error;
        addr_d     = addr_q;

        case (state_d)
            StBcHdr: begin
                tx_en_d   = 1'b1;
                tx_mode_d = TxHdr7e;
            end
            StAck, StTgtAck: begin
                rx_en_d   = 1'b1;
                rx_mode_d = RxAck;
            end
            StCccWord: begin
                tx_en_d   = 1'b1;
                tx_mode_d = dbp_d ? TxCccDb : TxCccZero;
            end
            StData: begin
                if (fetch_d) begin
                    rd_en_d = 1'b1;
                end else begin
                    tx_en_d   = 1'b1;
                    tx_mode_d = TxData;
                end
            end
            StCrc, StTgtCrc: begin
                tx_en_d   = 1'b1;
                tx_mode_d = TxCrc;
            end
            StRestart: begin
                tx_en_d    = 1'b1;
                tx_mode_d  = TxRestart;
                stall_en_d = 1'b1;
            end
            StExit: begin
                tx_en_d    = 1'b1;
                tx_mode_d  = TxExit;
                stall_en_d = 1'b1;
            end
            StTgtHdr: begin
                tx_en_d   = 1'b1;
                tx_mode_d = TxTgtHdr;
            end
            StTgtData: begin
                if (rnw_d) begin
                    rx_en_d   = 1'b1;
                    rx_mode_d = RxData;
                end else if (fetch_d) begin
                    rd_en_d = 1'b1;
                end else begin
                    tx_en_d   = 1'b1;
                    tx_mode_d = TxData;
                end
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                tx_en_d = 1'b0;
            end
        endcase

        if (rd_en_d)      addr_d = word_d[7:0];
        else if (wr_en_d) addr_d = word_q[7:0];
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q      <= StIdle;
            cmd_q        <= '0;
            dbp_q        <= 1'b0;
            toc_q        <= 1'b0;
            rnw_q        <= 1'b0;
            len_q        <= '0;
            tgt_cnt_q    <= '0;
            word_q       <= '0;
            fetch_q      <= 1'b0;
            tgt_idx_q    <= '0;
            retry_q      <= '0;
            last_q       <= 1'b0;
            stall_seen_q <= 1'b0;
            txd_seen_q   <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            tx_en_q      <= 1'b0;
            tx_mode_q    <= 4'd0;
            rx_en_q      <= 1'b0;
            rx_mode_q    <= 3'd0;
            stall_en_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= 8'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            dbp_q        <= dbp_d;
            toc_q        <= toc_d;
            rnw_q        <= rnw_d;
            len_q        <= len_d;
            tgt_cnt_q    <= tgt_cnt_d;
            word_q       <= word_d;
            fetch_q      <= fetch_d;
            tgt_idx_q    <= tgt_idx_d;
            retry_q      <= retry_d;
            last_q       <= last_d;
            stall_seen_q <= stall_seen_d;
            txd_seen_q   <= txd_seen_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            tx_en_q      <= tx_en_d;
            tx_mode_q    <= tx_mode_d;
            rx_en_q      <= rx_en_d;
            rx_mode_q    <= rx_mode_d;
            stall_en_q   <= stall_en_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            done_q       <= done_d;
        end
    end

    assign o_tx_en       = tx_en_q;
    assign o_tx_mode     = tx_mode_q;
    assign o_rx_en       = rx_en_q;
    assign o_rx_mode     = rx_mode_q;
    assign o_sclstall_en = stall_en_q;
    assign o_regf_rd_en  = rd_en_q;
    assign o_regf_wr_en  = wr_en_q;
    assign o_regf_addr   = addr_q;
    assign o_tgt_idx     = tgt_idx_q;
    assign o_engine_done = done_q;
    assign o_error       = err_q;
    assign o_error_code  = err_code_q;

endmodule

// File: tb/tb_hdr_ccc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hdr_ccc_sequencer
//
// Directed bench: plays the transmitter, receiver and SCL-stall roles, walks
// the sequencer through broadcast, direct read/write, NACK retry, receive
// error, header NACK, zero-length and mid-frame reset scenarios, and checks
// each expected word type and strobe against hand-derived values.
// -----------------------------------------------------------------------------
module tb_hdr_ccc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_engine_en;
    logic [7:0]  i_regf_CMD;
    logic        i_regf_DBP;
    logic        i_regf_TOC;
    logic        i_regf_RnW;
    logic [15:0] i_regf_DATA_LENGTH;
    logic [2:0]  i_regf_TGT_CNT;
    logic        i_tx_mode_done;
    logic        i_rx_mode_done;
    logic        i_rx_ack;
    logic        i_rx_error;
    logic        i_sclstall_stall_done;
    logic        o_tx_en;
    logic [3:0]  o_tx_mode;
    logic        o_rx_en;
    logic [2:0]  o_rx_mode;
    logic        o_sclstall_en;
    logic        o_regf_rd_en;
    logic        o_regf_wr_en;
    logic [7:0]  o_regf_addr;
    logic [1:0]  o_tgt_idx;
    logic        o_engine_done;
    logic        o_error;
    logic [1:0]  o_error_code;

    int vectors     = 0;
    int miscompares = 0;

    // Strobe observers, sampled mid-cycle
    logic [7:0] rd_addrs[$];
    int         wr_cnt   = 0;
    int         excl_cnt = 0;

    hdr_ccc_sequencer dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst_n),
        .i_engine_en           (i_engine_en),
        .i_regf_CMD            (i_regf_CMD),
        .i_regf_DBP            (i_regf_DBP),
        .i_regf_TOC            (i_regf_TOC),
        .i_regf_RnW            (i_regf_RnW),
        .i_regf_DATA_LENGTH    (i_regf_DATA_LENGTH),
        .i_regf_TGT_CNT        (i_regf_TGT_CNT),
        .i_tx_mode_done        (i_tx_mode_done),
        .i_rx_mode_done        (i_rx_mode_done),
        .i_rx_ack              (i_rx_ack),
        .i_rx_error            (i_rx_error),
        .i_sclstall_stall_done (i_sclstall_stall_done),
        .o_tx_en               (o_tx_en),
        .o_tx_mode             (o_tx_mode),
        .o_rx_en               (o_rx_en),
        .o_rx_mode             (o_rx_mode),
        .o_sclstall_en         (o_sclstall_en),
        .o_regf_rd_en          (o_regf_rd_en),
        .o_regf_wr_en          (o_regf_wr_en),
        .o_regf_addr           (o_regf_addr),
        .o_tgt_idx             (o_tgt_idx),
        .o_engine_done         (o_engine_done),
        .o_error               (o_error),
        .o_error_code          (o_error_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_regf_rd_en) rd_addrs.push_back(o_regf_addr);
        if (o_regf_wr_en) wr_cnt++;
        if (o_tx_en && o_rx_en) excl_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_tx_en, o_tx_mode, o_rx_en, o_rx_mode, o_sclstall_en, o_regf_rd_en,
                    o_regf_wr_en, o_regf_addr, o_tgt_idx, o_engine_done, o_error,
                    o_error_code});
    endfunction

    // Starts a frame, then scrambles the register fields to prove latching.
    task automatic start_frame(input logic [7:0] cmd, input logic dbp, input logic toc,
                               input logic rnw, input logic [15:0] len,
                               input logic [2:0] cnt);
        i_regf_CMD         = cmd;
        i_regf_DBP         = dbp;
        i_regf_TOC         = toc;
        i_regf_RnW         = rnw;
        i_regf_DATA_LENGTH = len;
        i_regf_TGT_CNT     = cnt;
        i_engine_en        = 1'b1;
        tick();
        i_engine_en        = 1'b0;
        i_regf_CMD         = ~cmd;
        i_regf_DBP         = ~dbp;
        i_regf_TOC         = ~toc;
        i_regf_RnW         = ~rnw;
        i_regf_DATA_LENGTH = ~len;
        i_regf_TGT_CNT     = ~cnt;
        chk("start error cleared", 32'({o_error, o_error_code}), 0);
    endtask

    task automatic wait_tx(input string tag, input logic [3:0] mode);
        int n = 0;
        while (!o_tx_en && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " tx_en/mode"}, 32'({o_tx_en, o_tx_mode}), 32'({1'b1, mode}));
        i_tx_mode_done = 1'b1;
        tick();
        i_tx_mode_done = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input logic [2:0] mode, input logic ack,
                           input logic err);
        int n = 0;
        while (!o_rx_en && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " rx_en/mode"}, 32'({o_rx_en, o_rx_mode}), 32'({1'b1, mode}));
        i_rx_ack       = ack;
        i_rx_error     = err;
        i_rx_mode_done = !err;
        tick();
        i_rx_ack       = 1'b0;
        i_rx_error     = 1'b0;
        i_rx_mode_done = 1'b0;
    endtask

    // tx-done and stall-done are returned in separate cycles.
    task automatic wait_stall(input string tag, input logic [3:0] mode);
        int n = 0;
        while (!o_sclstall_en && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " stall/tx/mode"}, 32'({o_sclstall_en, o_tx_en, o_tx_mode}),
            32'({2'b11, mode}));
        i_tx_mode_done = 1'b1;
        tick();
        i_tx_mode_done = 1'b0;
        chk({tag, " held for stall"}, 32'({o_sclstall_en, o_tx_mode}), 32'({1'b1, mode}));
        i_sclstall_stall_done = 1'b1;
        tick();
        i_sclstall_stall_done = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        chk({tag, " done pulse"}, 32'({o_engine_done, o_tx_en, o_rx_en}), 32'b100);
        tick();
        chk({tag, " done single"}, 32'(o_engine_done), 0);
    endtask

    task automatic run_bcast(input string tag);
        int base = rd_addrs.size();
        start_frame(8'h00, 1'b0, 1'b1, 1'b0, 16'd3, 3'd0);
        wait_tx({tag, " hdr"}, 4'd0);
        wait_rx({tag, " ack"}, 3'd0, 1'b1, 1'b0);
        wait_tx({tag, " ccc"}, 4'd2);
        wait_tx({tag, " d0"}, 4'd3);
        wait_tx({tag, " d1"}, 4'd3);
        wait_tx({tag, " crc"}, 4'd4);
        wait_stall({tag, " exit"}, 4'd7);
        end_frame(tag);
        chk({tag, " rd count"}, 32'(rd_addrs.size() - base), 2);
        if (rd_addrs.size() >= base + 2) begin
            chk({tag, " rd addr0"}, 32'(rd_addrs[base]), 0);
            chk({tag, " rd addr1"}, 32'(rd_addrs[base + 1]), 1);
        end
        chk({tag, " no error"}, 32'({o_error, o_error_code}), 0);
    endtask

    initial begin
        int base;
        rst_n                 = 1'b0;
        i_engine_en           = 1'b0;
        i_regf_CMD            = 8'h00;
        i_regf_DBP            = 1'b0;
        i_regf_TOC            = 1'b0;
        i_regf_RnW            = 1'b0;
        i_regf_DATA_LENGTH    = 16'd0;
        i_regf_TGT_CNT        = 3'd0;
        i_tx_mode_done        = 1'b0;
        i_rx_mode_done        = 1'b0;
        i_rx_ack              = 1'b0;
        i_rx_error            = 1'b0;
        i_sclstall_stall_done = 1'b0;

        // Reset state
        tick();
        chk("reset outputs", all_outs(), 0);
        tick();
        rst_n = 1'b1;

        // Broadcast, LEN = 3, accepted on the first edge after release
        run_bcast("bcast");

        // Direct read, two targets, one word each, TOC = 0
        base = wr_cnt;
        start_frame(8'h8B, 1'b0, 1'b0, 1'b1, 16'd2, 3'd2);
        wait_tx("dr hdr", 4'd0);
        wait_rx("dr ack", 3'd0, 1'b1, 1'b0);
        wait_tx("dr ccc", 4'd2);
        wait_tx("dr hcrc", 4'd4);
        wait_stall("dr rs0", 4'd6);
        chk("dr tgt_idx 0", 32'(o_tgt_idx), 0);
        wait_tx("dr thdr0", 4'd5);
        wait_rx("dr tack0", 3'd0, 1'b1, 1'b0);
        wait_rx("dr word0", 3'd1, 1'b0, 1'b0);
        wait_tx("dr tcrc0", 4'd4);
        wait_stall("dr rs1", 4'd6);
        chk("dr tgt_idx 1", 32'(o_tgt_idx), 1);
        wait_tx("dr thdr1", 4'd5);
        wait_rx("dr tack1", 3'd0, 1'b1, 1'b0);
        wait_rx("dr word1", 3'd1, 1'b0, 1'b0);
        wait_tx("dr tcrc1", 4'd4);
        wait_stall("dr final rs", 4'd6);
        end_frame("dr");
        chk("dr wr count", 32'(wr_cnt - base), 2);
        chk("dr no error", 32'({o_error, o_error_code}), 0);

        // NACK retry: target 0 NACKs three times, target 1 written
        base = rd_addrs.size();
        start_frame(8'h90, 1'b1, 1'b1, 1'b0, 16'd2, 3'd2);
        wait_tx("nk hdr", 4'd0);
        wait_rx("nk ack", 3'd0, 1'b1, 1'b0);
        wait_tx("nk ccc db", 4'd1);
        wait_tx("nk hcrc", 4'd4);
        for (int i = 0; i < 3; i++) begin
            wait_stall("nk rs", 4'd6);
            chk("nk retry tgt", 32'(o_tgt_idx), 0);
            wait_tx("nk thdr0", 4'd5);
            wait_rx("nk nack", 3'd0, 1'b0, 1'b0);
        end
        chk("nk code after exhaust", 32'({o_error, o_error_code}), 32'b101);
        wait_stall("nk rs next", 4'd6);
        chk("nk tgt 1", 32'(o_tgt_idx), 1);
        wait_tx("nk thdr1", 4'd5);
        wait_rx("nk tack1", 3'd0, 1'b1, 1'b0);
        wait_tx("nk wr word", 4'd3);
        wait_tx("nk tcrc1", 4'd4);
        wait_stall("nk exit", 4'd7);
        end_frame("nk");
        chk("nk rd count", 32'(rd_addrs.size() - base), 1);
        chk("nk error held", 32'({o_error, o_error_code}), 32'b101);

        // Receive error during target data
        start_frame(8'h8B, 1'b0, 1'b0, 1'b1, 16'd4, 3'd1);
        wait_tx("re hdr", 4'd0);
        wait_rx("re ack", 3'd0, 1'b1, 1'b0);
        wait_tx("re ccc", 4'd2);
        wait_tx("re hcrc", 4'd4);
        wait_stall("re rs", 4'd6);
        wait_tx("re thdr", 4'd5);
        wait_rx("re tack", 3'd0, 1'b1, 1'b0);
        wait_rx("re word", 3'd1, 1'b0, 1'b1);
        chk("re exit next", 32'({o_sclstall_en, o_tx_en, o_tx_mode}), 32'({2'b11, 4'd7}));
        chk("re code", 32'({o_error, o_error_code}), 32'b110);
        wait_stall("re exit", 4'd7);
        end_frame("re");

        // NACK of the broadcast header
        start_frame(8'h01, 1'b0, 1'b1, 1'b0, 16'd2, 3'd0);
        wait_tx("hn hdr", 4'd0);
        wait_rx("hn nack", 3'd0, 1'b0, 1'b0);
        chk("hn code", 32'({o_error, o_error_code}), 32'b101);
        wait_stall("hn exit", 4'd7);
        end_frame("hn");

        // Zero-length broadcast with TOC = 0: no data, restart then done
        base = rd_addrs.size();
        start_frame(8'h02, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0);
        wait_tx("z hdr", 4'd0);
        wait_rx("z ack", 3'd0, 1'b1, 1'b0);
        wait_tx("z ccc", 4'd2);
        wait_tx("z crc", 4'd4);
        wait_stall("z rs", 4'd6);
        end_frame("z");
        chk("z rd count", 32'(rd_addrs.size() - base), 0);

        // Reset in the middle of DATA, then a clean frame
        start_frame(8'h00, 1'b0, 1'b1, 1'b0, 16'd6, 3'd0);
        wait_tx("rs hdr", 4'd0);
        wait_rx("rs ack", 3'd0, 1'b1, 1'b0);
        wait_tx("rs ccc", 4'd2);
        wait_tx("rs d0", 4'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid-frame reset outputs", all_outs(), 0);
        #1;
        rst_n = 1'b1;
        run_bcast("post-reset");

        chk("tx/rx exclusive", 32'(excl_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
